// File: rtl/fetch_control_unit_pkg.sv
// Shared fetch front-end definitions: FSM state encoding, the NOP instruction
// word and the register/address field widths used across the pipeline.
package fetch_control_unit_pkg;

    localparam int REG_W  = 5;
    localparam int ADDR_W = 32;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } fcu_state_t;

endpackage

// File: rtl/fetch_control_unit_hazard_detect.sv
// Load-use hazard equation: the load in EX writes a register the instruction in
// ID reads. Register 0 is hardwired to zero, so it never creates a dependency.
// Purely combinational so the forwarding unit can reuse it.
module hazard_detect
    import fetch_control_unit_pkg::*;
(
    input  logic             mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hz
);

    // Flag a dependency on a non-zero load destination.
    always_comb begin
        hz = 1'b0;
        if (mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt))) begin
            hz = 1'b1;
        end else begin
            hz = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_control_unit.sv
// Fetch sequencing controller. Chooses each cycle whether the PC advances,
// redirects or holds, and whether IF/ID loads, holds or is flushed to a NOP.
// A redirect seen while instruction memory is waiting is parked in the
// pending register and replayed when memory becomes ready.
module fetch_control_unit
    import fetch_control_unit_pkg::*;
#(
    parameter bit DELAY_SLOT = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_ready,
    input  logic              id_ex_mem_read,
    input  logic [REG_W-1:0]  id_ex_rt,
    input  logic [REG_W-1:0]  if_id_rs,
    input  logic [REG_W-1:0]  if_id_rt,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              pc_le,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              ifid_le,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [CNT_W-1:0]  stall_count
);

    fcu_state_t        state_r;
    fcu_state_t        state_next_s;
    logic              pend_r;
    logic              pend_next_s;
    logic [ADDR_W-1:0] pend_target_r;
    logic [ADDR_W-1:0] pend_target_next_s;
    logic [CNT_W-1:0]  stall_count_r;
    logic              hz_s;
    logic              stalled_s;

    hazard_detect u_hazard_detect (
        .mem_read (id_ex_mem_read),
        .ex_rt    (id_ex_rt),
        .id_rs    (if_id_rs),
        .id_rt    (if_id_rt),
        .hz       (hz_s)
    );

    // State, pending redirect and stall counter; reset is asynchronous.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= BOOT;
            pend_r        <= 1'b0;
            pend_target_r <= {ADDR_W{1'b0}};
            stall_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_next_s;
            pend_r        <= pend_next_s;
            pend_target_r <= pend_target_next_s;
            if (stalled_s && !(&stall_count_r)) begin
                stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    // Next-state and output decode in priority: memory wait, hazard, redirect.
    always_comb begin
        state_next_s       = state_r;
        pend_next_s        = pend_r;
        pend_target_next_s = pend_target_r;
        pc_le              = 1'b0;
        pc_sel             = 1'b0;
        ifid_le            = 1'b0;
        ifid_flush         = 1'b0;
        idex_bubble        = 1'b0;

        case (state_r)
            BOOT: begin
                // PC held, IF/ID holds a NOP for exactly one cycle.
                ifid_flush   = 1'b1;
                state_next_s = RUN;
            end

            RUN: begin
                if (!imem_ready) begin
                    ifid_flush   = 1'b1;
                    state_next_s = MEM_WAIT;
                    if (branch_taken && !hz_s) begin
                        pend_next_s        = 1'b1;
                        pend_target_next_s = branch_target;
                    end else begin
                        pend_next_s        = pend_r;
                        pend_target_next_s = pend_target_r;
                    end
                end else if (hz_s) begin
                    // Branch operands are stale; ID re-presents the branch.
                    idex_bubble = 1'b1;
                end else if (branch_taken) begin
                    pc_le  = 1'b1;
                    pc_sel = 1'b1;
                    if (DELAY_SLOT) begin
                        ifid_le = 1'b1;
                    end else begin
                        ifid_flush = 1'b1;
                    end
                end else begin
                    pc_le   = 1'b1;
                    ifid_le = 1'b1;
                end
            end

            MEM_WAIT: begin
                if (!imem_ready) begin
                    ifid_flush = 1'b1;
                    // First redirect wins; later ones are dropped.
                    if (branch_taken && !pend_r) begin
                        pend_next_s        = 1'b1;
                        pend_target_next_s = branch_target;
                    end else begin
                        pend_next_s        = pend_r;
                        pend_target_next_s = pend_target_r;
                    end
                end else begin
                    state_next_s = RUN;
                    if (pend_r) begin
                        pc_le       = 1'b1;
                        pc_sel      = 1'b1;
                        pend_next_s = 1'b0;
                        if (DELAY_SLOT) begin
                            ifid_le = 1'b1;
                        end else begin
                            ifid_flush = 1'b1;
                        end
                    end else begin
                        pc_le   = 1'b1;
                        ifid_le = 1'b1;
                    end
                end
            end

            default: begin
                ifid_flush   = 1'b1;
                state_next_s = BOOT;
                pend_next_s  = 1'b0;
            end
        endcase
    end

    // Redirect address: a parked redirect overrides the live branch target.
    always_comb begin
        redirect_pc = {ADDR_W{1'b0}};
        if (state_r == BOOT) begin
            redirect_pc = {ADDR_W{1'b0}};
        end else if (pend_r) begin
            redirect_pc = pend_target_r;
        end else begin
            redirect_pc = branch_target;
        end
    end

    // A stalled cycle is any post-boot cycle in which the PC does not load.
    always_comb begin
        stalled_s = 1'b0;
        if ((state_r == RUN) || (state_r == MEM_WAIT)) begin
            stalled_s = !pc_le;
        end else begin
            stalled_s = 1'b0;
        end
    end

    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_fetch_control_unit.sv
// Directed bench for fetch_control_unit. Two instances share stimulus: one
// with a branch delay slot and a 16-bit counter, one without a delay slot and
// a 4-bit counter. Inputs change 1 time unit after the rising edge,
// combinational outputs are sampled on the falling edge, stall_count just
// after the rising edge.
module tb_fetch_control_unit;

    logic        clk;
    logic        reset;
    logic        imem_ready;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic        a_pc_le, a_pc_sel, a_ifid_le, a_ifid_flush, a_idex_bubble;
    logic [31:0] a_redirect_pc;
    logic [15:0] a_stall_count;
    logic        b_pc_le, b_pc_sel, b_ifid_le, b_ifid_flush, b_idex_bubble;
    logic [31:0] b_redirect_pc;
    logic [3:0]  b_stall_count;

    int err_cnt = 0;
    int chk_cnt = 0;

    fetch_control_unit #(.DELAY_SLOT(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .imem_ready(imem_ready),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc_le(a_pc_le), .pc_sel(a_pc_sel), .redirect_pc(a_redirect_pc),
        .ifid_le(a_ifid_le), .ifid_flush(a_ifid_flush),
        .idex_bubble(a_idex_bubble), .stall_count(a_stall_count)
    );

    fetch_control_unit #(.DELAY_SLOT(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .imem_ready(imem_ready),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc_le(b_pc_le), .pc_sel(b_pc_sel), .redirect_pc(b_redirect_pc),
        .ifid_le(b_ifid_le), .ifid_flush(b_ifid_flush),
        .idex_bubble(b_idex_bubble), .stall_count(b_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (obs !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ready     = 1'b1;
        id_ex_mem_read = 1'b0;
        id_ex_rt       = 5'd0;
        if_id_rs       = 5'd0;
        if_id_rt       = 5'd0;
        branch_taken   = 1'b0;
        branch_target  = 32'h0000_0000;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();

        // Held in reset
        @(negedge clk);
        check_value("rst_pc_le", {31'd0, a_pc_le}, 32'd0);
        check_value("rst_flush", {31'd0, a_ifid_flush}, 32'd1);
        check_value("rst_cnt", {16'd0, a_stall_count}, 32'd0);
        next_cycle();

        // Release: BOOT cycle
        reset = 1'b1;
        @(negedge clk);
        check_value("boot_pc_le", {31'd0, a_pc_le}, 32'd0);
        check_value("boot_ifid_le", {31'd0, a_ifid_le}, 32'd0);
        check_value("boot_flush", {31'd0, a_ifid_flush}, 32'd1);
        check_value("boot_redir", a_redirect_pc, 32'd0);
        next_cycle();
        check_value("boot_cnt", {16'd0, a_stall_count}, 32'd0);

        // First RUN cycle: normal advance
        @(negedge clk);
        check_value("run_pc_le", {31'd0, a_pc_le}, 32'd1);
        check_value("run_ifid_le", {31'd0, a_ifid_le}, 32'd1);
        check_value("run_pc_sel", {31'd0, a_pc_sel}, 32'd0);
        check_value("run_flush", {31'd0, a_ifid_flush}, 32'd0);
        next_cycle();
        check_value("run_cnt", {16'd0, a_stall_count}, 32'd0);

        // Load-use hazard on rs
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
        @(negedge clk);
        check_value("lu_pc_le", {31'd0, a_pc_le}, 32'd0);
        check_value("lu_ifid_le", {31'd0, a_ifid_le}, 32'd0);
        check_value("lu_bubble", {31'd0, a_idex_bubble}, 32'd1);
        next_cycle();
        check_value("lu_cnt_a", {16'd0, a_stall_count}, 32'd1);
        check_value("lu_cnt_b", {28'd0, b_stall_count}, 32'd1);

        // Load to r0 never stalls
        id_ex_rt = 5'd0; if_id_rs = 5'd0;
        @(negedge clk);
        check_value("r0_pc_le", {31'd0, a_pc_le}, 32'd1);
        check_value("r0_bubble", {31'd0, a_idex_bubble}, 32'd0);
        next_cycle();
        check_value("r0_cnt", {16'd0, a_stall_count}, 32'd1);

        // Taken branch in RUN
        idle_inputs();
        branch_taken = 1'b1; branch_target = 32'h0000_0040;
        @(negedge clk);
        check_value("br_pc_sel", {31'd0, a_pc_sel}, 32'd1);
        check_value("br_redir", a_redirect_pc, 32'h0000_0040);
        check_value("br_pc_le", {31'd0, a_pc_le}, 32'd1);
        check_value("br_ds_ifid_le", {31'd0, a_ifid_le}, 32'd1);
        check_value("br_ds_flush", {31'd0, a_ifid_flush}, 32'd0);
        check_value("br_nods_flush", {31'd0, b_ifid_flush}, 32'd1);
        check_value("br_nods_pc_le", {31'd0, b_pc_le}, 32'd1);
        next_cycle();

        // Hazard (via rt) together with a branch: branch ignored
        idle_inputs();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rt = 5'd8;
        branch_taken = 1'b1; branch_target = 32'h0000_0099;
        @(negedge clk);
        check_value("hzbr_pc_sel", {31'd0, a_pc_sel}, 32'd0);
        check_value("hzbr_pc_le", {31'd0, a_pc_le}, 32'd0);
        check_value("hzbr_bubble", {31'd0, a_idex_bubble}, 32'd1);
        next_cycle();
        check_value("hzbr_cnt", {16'd0, a_stall_count}, 32'd2);

        // Nothing was parked: redirect_pc follows the live target
        idle_inputs();
        branch_target = 32'h0000_0123;
        @(negedge clk);
        check_value("hzbr_nopend", a_redirect_pc, 32'h0000_0123);
        next_cycle();

        // Memory wait for 3 cycles with a redirect in cycle 2
        idle_inputs();
        imem_ready = 1'b0;
        @(negedge clk);
        check_value("mw1_pc_le", {31'd0, a_pc_le}, 32'd0);
        check_value("mw1_flush", {31'd0, a_ifid_flush}, 32'd1);
        next_cycle();
        branch_taken = 1'b1; branch_target = 32'h0000_0080;
        @(negedge clk);
        check_value("mw2_pc_le", {31'd0, a_pc_le}, 32'd0);
        next_cycle();
        branch_taken = 1'b1; branch_target = 32'h0000_00C0;
        @(negedge clk);
        check_value("mw3_first_wins", a_redirect_pc, 32'h0000_0080);
        check_value("mw3_pc_le", {31'd0, a_pc_le}, 32'd0);
        next_cycle();
        check_value("mw_cnt_a", {16'd0, a_stall_count}, 32'd5);
        check_value("mw_cnt_b", {28'd0, b_stall_count}, 32'd5);
        idle_inputs();
        branch_target = 32'h0000_0044;
        @(negedge clk);
        check_value("mw4_pc_sel", {31'd0, a_pc_sel}, 32'd1);
        check_value("mw4_redir", a_redirect_pc, 32'h0000_0080);
        check_value("mw4_pc_le", {31'd0, a_pc_le}, 32'd1);
        check_value("mw4_ds_ifid_le", {31'd0, a_ifid_le}, 32'd1);
        check_value("mw4_nods_flush", {31'd0, b_ifid_flush}, 32'd1);
        next_cycle();
        check_value("mw4_cnt", {16'd0, a_stall_count}, 32'd5);
        @(negedge clk);
        check_value("mw5_pend_clr", a_redirect_pc, 32'h0000_0044);
        check_value("mw5_pc_sel", {31'd0, a_pc_sel}, 32'd0);
        next_cycle();

        // Park a redirect in MEM_WAIT, then reset mid-wait
        idle_inputs();
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0100;
        next_cycle();
        branch_taken = 1'b0;
        @(negedge clk);
        check_value("pre_rst_pend", a_redirect_pc, 32'h0000_0100);
        next_cycle();
        reset = 1'b0;
        #1;
        check_value("mrst_pc_le", {31'd0, a_pc_le}, 32'd0);
        check_value("mrst_flush", {31'd0, a_ifid_flush}, 32'd1);
        check_value("mrst_redir", a_redirect_pc, 32'd0);
        check_value("mrst_cnt", {16'd0, a_stall_count}, 32'd0);
        next_cycle();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        check_value("mrst_boot_flush", {31'd0, a_ifid_flush}, 32'd1);
        next_cycle();
        branch_taken = 1'b1; branch_target = 32'h0000_0200;
        @(negedge clk);
        check_value("mrst_fresh_redir", a_redirect_pc, 32'h0000_0200);
        check_value("mrst_fresh_sel", {31'd0, a_pc_sel}, 32'd1);
        next_cycle();

        // Saturation: 2^16 + 5 consecutive stalled cycles
        idle_inputs();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd3; if_id_rs = 5'd3;
        for (int i = 0; i < 65541; i++) begin
            next_cycle();
        end
        check_value("sat_a", {16'd0, a_stall_count}, 32'h0000_FFFF);
        check_value("sat_b", {28'd0, b_stall_count}, 32'h0000_000F);
        next_cycle();
        check_value("sat_a_hold", {16'd0, a_stall_count}, 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
